fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one outstanding request at a time to
// instruction memory, buffers returned words in a small FIFO together with
// their addresses, and flushes everything on a control-flow redirect.
module fetch_stage #(
   parameter int              PC_W     = 9,
   parameter int              INS_W    = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [INS_W-1:0] imem_rdata,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INS_W-1:0] out_instr,
   output logic [PC_W-1:0]  out_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]      r_state;
   logic [PC_W-1:0] r_fetch_pc;
   logic [PC_W-1:0] r_drop_addr;   // address of the abandoned request while draining it
   logic [AW:0]     r_count;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;

   logic [PC_W-1:0]  r_buf_pc    [DEPTH];
   logic [INS_W-1:0] r_buf_instr [DEPTH];

   logic        w_push;
   logic        w_pop;
   logic [AW:0] w_count_next;

   assign w_pop        = (r_count != '0) && out_ready;
   assign w_push       = (r_state == S_REQ) && imem_ack && !redirect;
   assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

   assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
   // While draining, the old address must stay on the bus even though
   // fetch_pc already points at the redirect target.
   assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_fetch_pc;
   assign out_valid = (r_count != '0);
   assign out_instr = out_valid ? r_buf_instr[r_rptr] : '0;
   assign out_pc    = out_valid ? r_buf_pc[r_rptr]    : '0;

   // Request FSM and fetch address tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_drop_addr <= RESET_PC;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (redirect)
                  r_fetch_pc <= redirect_pc;
               else if (r_count < FULL)
                  r_state <= S_REQ;
            end
            S_REQ: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
                  if (imem_ack) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state     <= S_DROP;
                     r_drop_addr <= r_fetch_pc;
                  end
               end else if (imem_ack) begin
                  r_fetch_pc <= r_fetch_pc + PC_W'(4);
                  if (w_count_next >= FULL)
                     r_state <= S_IDLE;
               end
            end
            S_DROP: begin
               if (redirect)
                  r_fetch_pc <= redirect_pc;
               if (imem_ack)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Buffer occupancy and pointers; a redirect empties the buffer outright
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else if (redirect) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         r_count <= w_count_next;
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
      end
   end

   // Buffer storage; contents need no reset because reads are gated by count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_pc[r_wptr]    <= r_fetch_pc;
         r_buf_instr[r_wptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a transaction-level reference model
// and a scoreboard queue of expected {pc, instr} pairs.
module tb_fetch_stage;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [INS_W-1:0] ins;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_ack = 1'b0;
   logic [INS_W-1:0] imem_rdata = '0;
   logic             redirect = 1'b0;
   logic [PC_W-1:0]  redirect_pc = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [INS_W-1:0] out_instr;
   logic [PC_W-1:0]  out_pc;

   fetch_stage #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   ent_t            exp_q[$];
   bit              m_busy = 0;      // a normal request is outstanding
   bit              m_drop = 0;      // an abandoned request is being drained
   logic [PC_W-1:0] m_pc = '0;       // next address to fetch
   logic [PC_W-1:0] m_drop_addr = '0;
   bit              popped = 0;
   bit              in_rst = 1;
   bit              done = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one clock edge of the rules to the model (called just before the edge)
   task automatic model_step();
      int pre_count;
      pre_count = exp_q.size() + (popped ? 1 : 0);
      if (redirect) begin
         exp_q.delete();
         if (m_busy) begin
            m_busy = 0;
            if (!imem_ack) begin
               m_drop = 1;
               m_drop_addr = m_pc;
            end
         end else if (m_drop && imem_ack) begin
            m_drop = 0;
         end
         m_pc = redirect_pc;
      end else if (m_busy) begin
         if (imem_ack) begin
            exp_q.push_back('{pc: m_pc, ins: imem_rdata});
            m_pc = m_pc + 9'd4;
            if (exp_q.size() >= DEPTH) m_busy = 0;
         end
      end else if (m_drop) begin
         if (imem_ack) m_drop = 0;
      end else if (pre_count < DEPTH) begin
         m_busy = 1;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy = 0;
      m_drop = 0;
      m_pc = '0;
      m_drop_addr = '0;
      popped = 0;
   endtask

   task automatic cyc(input bit ack, input bit rdy, input bit redir, input logic [PC_W-1:0] rpc);
      @(negedge clk);
      #1;
      imem_ack    = ack;
      out_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      imem_rdata  = $urandom;
      #3;
      if (!in_rst) model_step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_req"},   64'(imem_req),  64'd0);
      chk({tag, "_addr"},  64'(imem_addr), 64'd0);
      chk({tag, "_pc"},    64'(out_pc),    64'd0);
      chk({tag, "_instr"}, 64'(out_instr), 64'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
      in_rst = 0;
      imem_ack = 1'b1;      // a stray ack right after release must be ignored
      out_ready = 1'b0;
      redirect = 1'b0;
      imem_rdata = $urandom;
      #3;
      model_step();
   endtask

   // Monitor: compares DUT outputs to the model and pops on each handshake
   initial begin
      ent_t e;
      while (!done) begin
         @(negedge clk);
         #3;
         if (!in_rst && !done) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("imem_req", 64'(imem_req), 64'(m_busy | m_drop));
            if (m_busy | m_drop)
               chk("imem_addr", 64'(imem_addr), 64'(m_drop ? m_drop_addr : m_pc));
            popped = 0;
            if (exp_q.size() == 0) begin
               chk("empty_pc", 64'(out_pc), 64'd0);
               chk("empty_instr", 64'(out_instr), 64'd0);
            end else if (out_valid && out_ready) begin
               e = exp_q.pop_front();
               popped = 1;
               chk("out_pc", 64'(out_pc), 64'(e.pc));
               chk("out_instr", 64'(out_instr), 64'(e.ins));
            end
         end
      end
   end

   // Stimulus
   initial begin
      int n;
      #2;
      check_reset_outputs("reset0");
      repeat (2) @(negedge clk);
      release_reset();

      // streaming: ack and ready tied high, runs past the 508->0 wrap
      for (int i = 0; i < 140; i++) cyc(1, 1, 0, '0);

      // downstream stalled: buffer fills to DEPTH and requests stop
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, '0);
      chk("full_count", 64'(exp_q.size()), 64'(DEPTH));

      // flush a buffered state, restart at 0x40
      cyc(1, 1, 0, '0);
      cyc(0, 0, 1, 9'h040);
      for (int i = 0; i < 6; i++) cyc(1, 1, 0, '0);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 99) < 8,
             PC_W'($urandom_range(0, 511)));

      // drive into DROP: redirect to 0x80 while a request waits with ack low
      cyc(0, 0, 1, 9'h00C);
      n = 0;
      while (!m_busy && n < 10) begin
         cyc(0, 0, 0, '0);
         n++;
      end
      chk("reach_req", 64'(m_busy), 64'd1);
      cyc(0, 0, 1, 9'h080);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      cyc(1, 1, 0, '0);          // drained data must not be buffered
      for (int i = 0; i < 6; i++) cyc(1, 1, 0, '0);

      // DROP again, then reset while draining
      cyc(0, 0, 1, 9'h100);
      n = 0;
      while (!m_busy && n < 10) begin
         cyc(0, 0, 0, '0);
         n++;
      end
      cyc(0, 0, 1, 9'h1F0);
      chk("in_drop", 64'(m_drop), 64'd1);
      @(negedge clk);
      #1;
      in_rst = 1;
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_drop");
      model_reset();
      repeat (2) @(negedge clk);
      release_reset();
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, '0);

      done = 1;
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
